// File: rtl/cdb_pkg.sv
// Common Data Bus definitions shared by the CDB arbiter, the reservation
// stations and the register-status table.
package cdb_pkg;

  // Reservation-station tag width and result width of the core.
  localparam int LABEL_W = 5;
  localparam int DATA_W  = 32;

  // Tag value meaning "no producer"; a result carrying it is never broadcast.
  localparam int unsigned NULL_LABEL = 0;

  // One broadcast on the CDB as seen by every consumer (BCEN/BClabel/BCdata).
  typedef struct packed {
    logic               en;
    logic [LABEL_W-1:0] label;
    logic [DATA_W-1:0]  data;
  } cdb_bcast_t;

  // Index that lies 'off' positions after 'base' on a ring of 'n' slots.
  function automatic int rr_wrap(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selector for the CDB arbiter.
// Default build: round-robin search starting one slot after 'ptr'.
// CDB_FIXED_PRIO_EN defined: lowest candidate index wins and 'ptr' is ignored.
// The pointer register itself lives in the instantiating module.
module rr_arbiter
  import cdb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [IDX_W-1:0] ptr,
  input  logic [N-1:0]     cand,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

`ifdef CDB_FIXED_PRIO_EN

  // Priority mode has no pointer; fold it into a sink so it is visibly dropped.
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Scan from the top down so the lowest-index candidate is the last writer.
  always_comb begin : fixed_search
    gnt     = '0;
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        gnt     = '0;
        gnt[i]  = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
  end

`else

  // Walk the ring from ptr+1 and take the first candidate found.
  always_comb begin : rr_search
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = rr_wrap(int'(ptr), k, N);
      if (!found && cand[IDX_W'(idx)]) begin
        found               = 1'b1;
        gnt[IDX_W'(idx)]    = 1'b1;
        gnt_idx             = IDX_W'(idx);
      end
    end
  end

`endif

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: shares the Common Data Bus between N_REQ functional-unit
// result ports. Each port has a one-entry holding buffer; one buffered
// result is broadcast per cycle on the registered (bc_en, bc_label, bc_data)
// triple with bc_src naming the winning port.
// Build option: CDB_FIXED_PRIO_EN selects fixed lowest-index priority instead
// of round-robin; the round-robin pointer is then not built.
//
// Handshake: a transfer on port i happens on a rising edge where
// req_valid[i] && req_ready[i]. req_ready[i] is combinational and is high when
// the buffer is empty or is being granted this cycle (drain and refill on the
// same edge). Once req_valid[i] is raised the requester holds it, the label
// and the data unchanged until the transfer edge; req_valid never depends on
// req_ready.
module cdb_arbiter #(
  parameter int  N_REQ   = 4,
  parameter int  DATA_W  = cdb_pkg::DATA_W,
  parameter int  LABEL_W = cdb_pkg::LABEL_W,
  localparam int IDX_W   = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*LABEL_W-1:0] req_label,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     bc_en,
  output logic [LABEL_W-1:0]       bc_label,
  output logic [DATA_W-1:0]        bc_data,
  output logic [IDX_W-1:0]         bc_src,
  output logic                     tag_err
);

  localparam logic [LABEL_W-1:0] NULL_TAG = LABEL_W'(cdb_pkg::NULL_LABEL);

  // Holding buffers, one per requester.
  logic [N_REQ-1:0]   buf_v;
  logic [LABEL_W-1:0] buf_label [N_REQ];
  logic [DATA_W-1:0]  buf_data  [N_REQ];

  // Unpacked views of the incoming buses.
  logic [LABEL_W-1:0] in_label [N_REQ];
  logic [DATA_W-1:0]  in_data  [N_REQ];
  logic [N_REQ-1:0]   in_null;

  // Arbitration signals.
  logic [N_REQ-1:0]   cand;
  logic [N_REQ-1:0]   gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [N_REQ-1:0]   xfer;
  logic [IDX_W-1:0]   arb_ptr;

  // Slice the packed request buses and flag candidates per port.
  for (genvar g = 0; g < N_REQ; g++) begin : g_port
    assign in_label[g] = req_label[g*LABEL_W +: LABEL_W];
    assign in_data[g]  = req_data[g*DATA_W +: DATA_W];
    assign in_null[g]  = (in_label[g] == NULL_TAG);
    // A null-tagged entry is never stored, but the tag test keeps the
    // "never broadcast tag 0" guarantee local to the grant path.
    assign cand[g]     = buf_v[g] && (buf_label[g] != NULL_TAG);
  end

  assign gnt_any   = |gnt;
  assign req_ready = ~buf_v | gnt;
  assign xfer      = req_valid & req_ready;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .ptr     (arb_ptr),
    .cand    (cand),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

`ifdef CDB_FIXED_PRIO_EN

  assign arb_ptr = '0;

`else

  logic [IDX_W-1:0] rr_ptr;

  // Remember the last winner so the next search starts just after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= IDX_W'(N_REQ - 1);
    end else if (gnt_any) begin
      rr_ptr <= gnt_idx;
    end
  end

  assign arb_ptr = rr_ptr;

`endif

  // Capture offered results; a granted entry empties unless refilled on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_v <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        buf_label[i] <= '0;
        buf_data[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (xfer[i]) begin
          buf_v[i]     <= !in_null[i];
          buf_label[i] <= in_label[i];
          buf_data[i]  <= in_data[i];
        end else if (gnt[i]) begin
          buf_v[i] <= 1'b0;
        end
      end
    end
  end

  // Register the broadcast; the payload holds when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc_en    <= 1'b0;
      bc_label <= '0;
      bc_data  <= '0;
      bc_src   <= '0;
    end else if (gnt_any) begin
      bc_en    <= 1'b1;
      bc_label <= buf_label[gnt_idx];
      bc_data  <= buf_data[gnt_idx];
      bc_src   <= gnt_idx;
    end else begin
      bc_en    <= 1'b0;
    end
  end

  // Sticky flag for any accepted result that carried the null tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_err <= 1'b0;
    end else if (|(xfer & in_null)) begin
      tag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter (default round-robin build; the arbitration
// order in the reference model follows CDB_FIXED_PRIO_EN when defined).
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int NR = 4;
  localparam int LW = LABEL_W;
  localparam int DW = DATA_W;
  localparam int IW = $clog2(NR);
  localparam int TW = IW + LW + DW;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*LW-1:0] req_label;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             bc_en;
  logic [LW-1:0]    bc_label;
  logic [DW-1:0]    bc_data;
  logic [IW-1:0]    bc_src;
  logic             tag_err;

  cdb_arbiter #(
    .N_REQ   (NR),
    .DATA_W  (DW),
    .LABEL_W (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_label (req_label),
    .req_data  (req_data),
    .req_ready (req_ready),
    .bc_en     (bc_en),
    .bc_label  (bc_label),
    .bc_data   (bc_data),
    .bc_src    (bc_src),
    .tag_err   (tag_err)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- counters and scoreboard ----------------
  int vectors;
  int miscompares;
  // Accepted, not yet broadcast results as {src, label, data}, order-free.
  logic [TW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  bit            m_v     [NR];
  logic [LW-1:0] m_label [NR];
  logic [DW-1:0] m_data  [NR];
  int            m_last;
  bit            m_tag_err;
  logic [TW-1:0] m_bc;
  logic [NR-1:0] last_xfer;

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      m_v[i]     = 1'b0;
      m_label[i] = '0;
      m_data[i]  = '0;
    end
    m_last    = NR - 1;
    m_tag_err = 1'b0;
    m_bc      = '0;
    last_xfer = '0;
    exp_q.delete();
  endfunction

  // Which buffered requester should win this cycle (-1 when none).
  function automatic int model_pick();
`ifdef CDB_FIXED_PRIO_EN
    for (int i = 0; i < NR; i++) if (m_v[i]) return i;
`else
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (m_last + k) % NR;
      if (m_v[i]) return i;
    end
`endif
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic v, input logic [LW-1:0] l,
                         input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_label[i*LW +: LW] = l;
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, '0, '0);
  endtask

  // One clock: check ready, advance the model on the edge, check the broadcast.
  // Entered and left at a falling edge with the inputs for this cycle set.
  task automatic cycle();
    int            g;
    int            pos;
    logic [NR-1:0] exp_rdy;
    logic [TW-1:0] obs;
    g = model_pick();
    for (int i = 0; i < NR; i++) exp_rdy[i] = !m_v[i] || (g == i);
    #1;
    vectors++;
    if (req_ready !== exp_rdy) begin
      miscompares++;
      $display("FAIL req_ready: got %b expected %b", req_ready, exp_rdy);
    end
    last_xfer = req_valid & exp_rdy;
    @(posedge clk);
    if (g >= 0) begin
      m_bc    = {IW'(g), m_label[g], m_data[g]};
      m_v[g]  = 1'b0;
      m_last  = g;
    end
    for (int i = 0; i < NR; i++) begin
      if (last_xfer[i]) begin
        if (req_label[i*LW +: LW] == '0) begin
          m_tag_err = 1'b1;
        end else begin
          m_v[i]     = 1'b1;
          m_label[i] = req_label[i*LW +: LW];
          m_data[i]  = req_data[i*DW +: DW];
          exp_q.push_back({IW'(i), req_label[i*LW +: LW], req_data[i*DW +: DW]});
        end
      end
    end
    @(negedge clk);
    vectors++;
    if (bc_en !== (g >= 0)) begin
      miscompares++;
      $display("FAIL bc_en: got %b expected %b", bc_en, (g >= 0));
    end
    vectors++;
    if ({bc_src, bc_label, bc_data} !== m_bc) begin
      miscompares++;
      $display("FAIL bc_triple: got src=%0d label=%0d data=%h expected src=%0d label=%0d data=%h",
               bc_src, bc_label, bc_data, m_bc[TW-1 -: IW], m_bc[DW +: LW], m_bc[DW-1:0]);
    end
    if (bc_en === 1'b1) begin
      obs = {bc_src, bc_label, bc_data};
      pos = -1;
      for (int k = 0; k < exp_q.size(); k++) begin
        if (pos < 0 && exp_q[k] == obs) pos = k;
      end
      vectors++;
      if (pos < 0) begin
        miscompares++;
        $display("FAIL bc_unknown: got %h expected an accepted, unbroadcast result", obs);
      end else begin
        exp_q.delete(pos);
      end
    end
    vectors++;
    if (tag_err !== m_tag_err) begin
      miscompares++;
      $display("FAIL tag_err: got %b expected %b", tag_err, m_tag_err);
    end
  endtask

  // Assert reset between edges, check the async clear, release on a falling edge.
  task automatic apply_reset(input int n);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bc_en, bc_label, bc_data, bc_src, tag_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got en=%b label=%0d data=%h src=%0d tag_err=%b expected all 0",
               bc_en, bc_label, bc_data, bc_src, tag_err);
    end
    vectors++;
    if (req_ready !== '1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b expected %b", req_ready, {NR{1'b1}});
    end
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Idle until every buffer drained, then require nothing left unbroadcast.
  task automatic drain();
    idle_all();
    repeat (NR + 2) cycle();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d results never broadcast expected 0", exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    req_valid = NR'($urandom);
    req_label = (NR*LW)'($urandom);
    req_data  = {$urandom, $urandom, $urandom, $urandom};
    apply_reset(3);
    idle_all();
    cycle();
    vectors++;
    if (req_ready !== 4'hF || bc_en !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: got ready=%b en=%b expected ready=1111 en=0", req_ready, bc_en);
    end
  endtask

  task automatic test_single();
    set_req(2, 1'b1, 5'd9, 32'hDEADBEEF);
    cycle();
    idle_all();
    cycle();
    vectors++;
    if (bc_en !== 1'b1 || bc_label !== 5'd9 || bc_data !== 32'hDEADBEEF || bc_src !== 2'd2) begin
      miscompares++;
      $display("FAIL single: got en=%b label=%0d data=%h src=%0d expected en=1 label=9 data=deadbeef src=2",
               bc_en, bc_label, bc_data, bc_src);
    end
    cycle();
    vectors++;
    if (bc_en !== 1'b0) begin
      miscompares++;
      $display("FAIL single_off: got en=%b expected 0", bc_en);
    end
  endtask

  task automatic test_round_robin();
    apply_reset(1);
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, LW'(i + 1), $urandom);
    cycle();
    for (int k = 0; k < 2 * NR; k++) begin
      for (int i = 0; i < NR; i++) begin
        if (last_xfer[i]) set_req(i, 1'b1, LW'(i + 1), $urandom);
      end
      cycle();
      vectors++;
`ifdef CDB_FIXED_PRIO_EN
      if (bc_en !== 1'b1 || bc_src !== '0) begin
        miscompares++;
        $display("FAIL fixed_prio: got en=%b src=%0d expected en=1 src=0", bc_en, bc_src);
      end
`else
      if (bc_en !== 1'b1 || bc_label !== LW'((k % NR) + 1)) begin
        miscompares++;
        $display("FAIL rr_order: step %0d got en=%b label=%0d expected en=1 label=%0d",
                 k, bc_en, bc_label, (k % NR) + 1);
      end
`endif
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d1a;
    logic [DW-1:0] d1b;
    logic [DW-1:0] d3;
    d1a = $urandom;
    d1b = $urandom;
    d3  = $urandom;
    apply_reset(1);
    set_req(2, 1'b1, 5'd2, $urandom);
    cycle();
    idle_all();
    cycle();                           // requester 2 wins; it becomes the last winner
    set_req(1, 1'b1, 5'd11, d1a);
    set_req(3, 1'b1, 5'd13, d3);
    cycle();                           // both buffers fill on the same edge
    set_req(3, 1'b0, '0, '0);
    set_req(1, 1'b1, 5'd12, d1b);      // new result waits on a full buffer
`ifndef CDB_FIXED_PRIO_EN
    #1;
    vectors++;
    if (req_ready[1] !== 1'b0 || req_ready[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_ready: got ready=%b expected ready[1]=0 ready[3]=1", req_ready);
    end
`endif
    cycle();
`ifndef CDB_FIXED_PRIO_EN
    vectors++;
    if (bc_src !== 2'd3 || bc_label !== 5'd13 || bc_data !== d3) begin
      miscompares++;
      $display("FAIL bp_first: got src=%0d label=%0d expected src=3 label=13", bc_src, bc_label);
    end
    #1;
    vectors++;
    if (req_ready[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_refill_ready: got %b expected 1", req_ready[1]);
    end
    cycle();                           // 1 granted and refilled on the same edge
    vectors++;
    if (bc_src !== 2'd1 || bc_label !== 5'd11 || bc_data !== d1a) begin
      miscompares++;
      $display("FAIL bp_second: got src=%0d label=%0d expected src=1 label=11", bc_src, bc_label);
    end
    idle_all();
    cycle();
    vectors++;
    if (bc_en !== 1'b1 || bc_label !== 5'd12 || bc_data !== d1b) begin
      miscompares++;
      $display("FAIL bp_third: got en=%b label=%0d data=%h expected en=1 label=12 data=%h",
               bc_en, bc_label, bc_data, d1b);
    end
`endif
    drain();
  endtask

  task automatic test_tag0();
    set_req(0, 1'b1, 5'd0, 32'h1);
    set_req(2, 1'b1, 5'd7, $urandom);
    cycle();
    vectors++;
    if (tag_err !== 1'b1) begin
      miscompares++;
      $display("FAIL tag0_set: got %b expected 1", tag_err);
    end
    idle_all();
    cycle();
    vectors++;
    if (bc_en !== 1'b1 || bc_src !== 2'd2 || bc_label !== 5'd7) begin
      miscompares++;
      $display("FAIL tag0_other: got en=%b src=%0d label=%0d expected en=1 src=2 label=7",
               bc_en, bc_src, bc_label);
    end
    cycle();
    vectors++;
    if (bc_en !== 1'b0) begin
      miscompares++;
      $display("FAIL tag0_no_bc: got en=%b expected 0", bc_en);
    end
    repeat (3) cycle();
    vectors++;
    if (tag_err !== 1'b1) begin
      miscompares++;
      $display("FAIL tag0_sticky: got %b expected 1", tag_err);
    end
  endtask

  task automatic test_random(input int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] || last_xfer[i]) begin
          if ($urandom_range(0, 99) < 55)
            set_req(i, 1'b1, LW'($urandom_range(1, (1 << LW) - 1)), $urandom);
          else
            set_req(i, 1'b0, '0, '0);
        end
      end
      cycle();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int seen;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, LW'(i + 20), $urandom);
    cycle();                           // four buffers fill
    idle_all();
    cycle();                           // one broadcast in flight, three still buffered
    apply_reset(2);
    seen = 0;
    repeat (6) begin
      cycle();
      if (bc_en === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL reset_mid: got %0d broadcasts after reset expected 0", seen);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    req_valid   = '0;
    req_label   = '0;
    req_data    = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_tag0();
    test_random(400);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
